pipe_stage_elastic: RTL and testbench



---
 rtl/pipe_stage_elastic.sv | 78 +++++++
 tb/tb_pipe_stage_elastic.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: valid/ready handshake, one-entry skid buffer,
// synchronous flush, bubble insertion (control field zeroed) and saturating perf counters.
module pipe_stage_elastic #(
   parameter int WIDTH  = 64,
   parameter int CTRL_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic             Clk,
   input  logic             R,
   input  logic             flush,
   input  logic             bubble,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] D,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Q,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt
);

   logic             skid_valid;
   logic [WIDTH-1:0] skid_data;
   logic [WIDTH-1:0] word;
   logic             accept;
   logic             adv;

   // in_ready depends only on registered state plus flush/R, never on in_valid/out_ready
   assign in_ready = ~skid_valid & ~flush & ~R;
   assign accept   = in_valid & in_ready;
   assign adv      = ~out_valid | out_ready;

   always_comb begin
      word = D;
      if (bubble) word[CTRL_W-1:0] = '0;
   end

   always_ff @(posedge Clk or posedge R) begin
      if (R) begin
         Q          <= '0;
         out_valid  <= 1'b0;
         skid_data  <= '0;
         skid_valid <= 1'b0;
      end else if (flush) begin
         Q          <= '0;
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (adv) begin
         if (skid_valid) begin
            Q          <= skid_data;
            out_valid  <= 1'b1;
            skid_valid <= 1'b0;
         end else if (accept) begin
            Q         <= word;
            out_valid <= 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end else if (accept) begin
         skid_data  <= word;
         skid_valid <= 1'b1;
      end
   end

   always_ff @(posedge Clk or posedge R) begin
      if (R) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (!flush && out_valid && !out_ready && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
         // accept is already low during flush, so a flushed bubble is not counted
         if (accept && bubble && bubble_cnt != '1)
            bubble_cnt <= bubble_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic: queue-based scoreboard of accepted words
// plus a second narrow instance for counter saturation.
`timescale 1ns/1ps
module tb_pipe_stage_elastic;

   logic        clk;
   logic        r;
   logic        flush, bubble, in_valid, out_ready;
   logic [63:0] d;
   logic        in_ready, out_valid;
   logic [63:0] q;
   logic [15:0] stall_cnt, bubble_cnt;

   logic        s_in_valid, s_out_ready;
   logic [7:0]  s_d;
   logic        s_in_ready, s_out_valid;
   logic [7:0]  s_q;
   logic [3:0]  s_stall_cnt, s_bubble_cnt;

   int checks   = 0;
   int failures = 0;

   logic [63:0] sb[$];
   logic [63:0] exp_q;
   logic [15:0] exp_stall, exp_bubble;

   pipe_stage_elastic #(.WIDTH(64), .CTRL_W(16), .CNT_W(16)) u_dut (
      .Clk(clk), .R(r), .flush(flush), .bubble(bubble),
      .in_valid(in_valid), .in_ready(in_ready), .D(d),
      .out_valid(out_valid), .out_ready(out_ready), .Q(q),
      .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
   );

   pipe_stage_elastic #(.WIDTH(8), .CTRL_W(4), .CNT_W(4)) u_sat (
      .Clk(clk), .R(r), .flush(1'b0), .bubble(1'b0),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .D(s_d),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .Q(s_q),
      .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #2 clk = ~clk;
   end

   function automatic logic [63:0] mdl_w(input logic [63:0] x, input logic b);
      return b ? (x & 64'hFFFF_FFFF_FFFF_0000) : x;
   endfunction

   task automatic model_clear();
      sb.delete();
      exp_q      = '0;
      exp_stall  = '0;
      exp_bubble = '0;
   endtask

   // One clock edge; scoreboard and reference counters advance from the model's own state.
   task automatic step();
      bit m_rdy, acc, pop, stall;
      m_rdy = (sb.size() < 2) && !flush;
      acc   = in_valid && m_rdy;
      pop   = (sb.size() > 0) && out_ready;
      stall = (sb.size() > 0) && !out_ready;
      @(posedge clk);
      if (flush) begin
         sb.delete();
         exp_q = '0;
      end else begin
         if (stall && exp_stall != 16'hFFFF) exp_stall++;
         if (pop) void'(sb.pop_front());
         if (acc) begin
            sb.push_back(mdl_w(d, bubble));
            if (bubble && exp_bubble != 16'hFFFF) exp_bubble++;
         end
         if (sb.size() > 0) exp_q = sb[0];
      end
      #1;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (q !== 64'h0) begin failures++; $display("FAIL reset_q got=%h exp=0", q); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      #2 r = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (stall_cnt !== 16'h0 || bubble_cnt !== 16'h0) begin
         failures++; $display("FAIL reset_counters got=%h/%h exp=0/0", stall_cnt, bubble_cnt); end
      model_clear();
   endtask

   task automatic test_streaming();
      logic [63:0] base;
      base = 64'h0000_0001_0000_00A5;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int unsigned i = 0; i < 3; i++) begin
         d = base + 64'(i);
         step();
         checks++; if (q !== base + 64'(i) || q !== exp_q) begin
            failures++; $display("FAIL stream_q[%0d] got=%h exp=%h", i, q, base + 64'(i)); end
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, out_valid); end
      end
      in_valid = 1'b0;
      step();
      checks++; if (out_valid !== 1'b0 || q !== 64'h0000_0001_0000_00A7) begin
         failures++; $display("FAIL stream_drain got=%b/%h exp=0/00000001000000a7", out_valid, q); end
      checks++; if (stall_cnt !== 16'h0) begin failures++; $display("FAIL stream_stall got=%0d exp=0", stall_cnt); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      d = 64'h11; step();
      d = 64'h22; step();
      in_valid = 1'b0;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL skid_in_ready got=%b exp=0", in_ready); end
      for (int unsigned i = 0; i < 3; i++) begin
         step();
         checks++; if (q !== 64'h11 || out_valid !== 1'b1) begin
            failures++; $display("FAIL skid_hold[%0d] got=%b/%h exp=1/11", i, out_valid, q); end
      end
      checks++; if (stall_cnt !== exp_stall || stall_cnt !== 16'd4) begin
         failures++; $display("FAIL skid_stall got=%0d exp=%0d", stall_cnt, exp_stall); end
      out_ready = 1'b1;
      step();
      checks++; if (q !== 64'h22 || q !== exp_q || out_valid !== 1'b1) begin
         failures++; $display("FAIL skid_release got=%b/%h exp=1/22", out_valid, q); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL skid_ready_back got=%b exp=1", in_ready); end
      step();
      checks++; if (out_valid !== 1'b0 || sb.size() != 0) begin
         failures++; $display("FAIL skid_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_bubble();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      bubble    = 1'b1;
      d = 64'hDEAD_BEEF_1234_FFFF;
      step();
      in_valid = 1'b0;
      bubble   = 1'b0;
      checks++; if (q !== 64'hDEAD_BEEF_1234_0000 || out_valid !== 1'b1) begin
         failures++; $display("FAIL bubble_q got=%b/%h exp=1/deadbeef12340000", out_valid, q); end
      checks++; if (bubble_cnt !== 16'd1 || bubble_cnt !== exp_bubble) begin
         failures++; $display("FAIL bubble_cnt got=%0d exp=1", bubble_cnt); end
      step();
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      d = 64'h33; step();
      d = 64'h44; step();
      checks++; if (in_ready !== 1'b0 || q !== 64'h33) begin
         failures++; $display("FAIL flush_full got=%b/%h exp=0/33", in_ready, q); end
      flush  = 1'b1;
      bubble = 1'b1;
      d = 64'h55;
      #0.1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
      step();
      flush    = 1'b0;
      bubble   = 1'b0;
      in_valid = 1'b0;
      #0.1;
      checks++; if (out_valid !== 1'b0 || q !== 64'h0 || q !== exp_q) begin
         failures++; $display("FAIL flush_clear got=%b/%h exp=0/0", out_valid, q); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
      checks++; if (bubble_cnt !== exp_bubble || stall_cnt !== exp_stall) begin
         failures++; $display("FAIL flush_counters got=%0d/%0d exp=%0d/%0d", stall_cnt, bubble_cnt, exp_stall, exp_bubble); end
      out_ready = 1'b1;
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_dropped got=%b exp=0", out_valid); end
   endtask

   task automatic test_saturation();
      s_out_ready = 1'b0;
      s_in_valid  = 1'b1;
      s_d = 8'h5A;
      step();
      s_in_valid = 1'b0;
      for (int unsigned i = 0; i < 20; i++) step();
      checks++; if (s_stall_cnt !== 4'hF) begin failures++; $display("FAIL sat_stall got=%0d exp=15", s_stall_cnt); end
      checks++; if (s_q !== 8'h5A || s_out_valid !== 1'b1) begin
         failures++; $display("FAIL sat_hold got=%b/%h exp=1/5a", s_out_valid, s_q); end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      bubble    = 1'b1;
      d = 64'h77; step();
      in_valid = 1'b0;
      bubble   = 1'b0;
      checks++; if (out_valid !== 1'b1 || q !== 64'h0 || bubble_cnt !== exp_bubble) begin
         failures++; $display("FAIL pre_async got=%b/%h/%0d exp=1/0/%0d", out_valid, q, bubble_cnt, exp_bubble); end
      r = 1'b1;
      #0.5;
      checks++; if (q !== 64'h0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
         failures++; $display("FAIL async_outputs got=%b/%h/%b exp=0/0/0", out_valid, q, in_ready); end
      checks++; if (stall_cnt !== 16'h0 || bubble_cnt !== 16'h0) begin
         failures++; $display("FAIL async_counters got=%0d/%0d exp=0/0", stall_cnt, bubble_cnt); end
      checks++; if (s_stall_cnt !== 4'h0 || s_bubble_cnt !== 4'h0 || s_q !== 8'h0 || s_out_valid !== 1'b0) begin
         failures++; $display("FAIL async_sat got=%0d/%0d/%h/%b exp=0/0/0/0", s_stall_cnt, s_bubble_cnt, s_q, s_out_valid); end
      r = 1'b0;
      model_clear();
      #0.1;
      checks++; if (in_ready !== 1'b1 || s_in_ready !== 1'b1) begin
         failures++; $display("FAIL async_release got=%b/%b exp=1/1", in_ready, s_in_ready); end
      step();
      checks++; if (out_valid !== 1'b0 || q !== 64'h0) begin
         failures++; $display("FAIL async_discard got=%b/%h exp=0/0", out_valid, q); end
   endtask

   initial begin
      r = 1'b1;
      flush = 1'b0; bubble = 1'b0; in_valid = 1'b0; out_ready = 1'b0; d = '0;
      s_in_valid = 1'b0; s_out_ready = 1'b0; s_d = '0;
      model_clear();
      test_reset();
      test_streaming();
      test_backpressure();
      test_bubble();
      test_flush();
      test_saturation();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
